otter_fetch_stage: RTL and testbench

Instruction-fetch stage of the pipelined OTTER. It holds the fetch PC and selects the next PC from the PC_SRC code and target addresses produced by the execute-stage branch condition/address generator. It runs a req/ack handshake to instruction memory and presents PC/IR/valid to decode through a stall-able output register with a one-entry skid buffer. Redirects squash wrong-path fetches, including a memory response that is still in flight.

---
 rtl/otter_fetch_stage.sv | 154 +++++++++++++++
 tb/tb_otter_fetch_stage.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/otter_fetch_stage.sv
// rtl/otter_fetch_stage.sv - OTTER instruction-fetch stage: PC select, imem req/ack, skid-buffered IF register
// Optional misaligned-target flag: OTTER_FETCH_MISALIGN_EN
module otter_fetch_stage #(
    parameter logic [31:0] RESET_VEC = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [2:0]  PC_SRC,
    input  logic [31:0] JALR,
    input  logic [31:0] BRANCH,
    input  logic [31:0] JAL,
    input  logic [31:0] MTVEC,
    input  logic [31:0] MEPC,
    input  logic        STALL,
    output logic        IMEM_REQ,
    output logic [31:0] IMEM_ADDR,
    input  logic        IMEM_ACK,
    input  logic [31:0] IMEM_RDATA,
    output logic        IF_VALID,
    output logic [31:0] IF_PC,
    output logic [31:0] IF_IR,
    output logic        MISALIGN
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DRAIN, S_HOLD} state_t;

    state_t      state, state_nxt;
    logic [31:0] fpc;
    logic        skid_valid;
    logic [31:0] skid_pc, skid_ir;
    logic        redirect;
    logic [31:0] target_raw;
    logic        accept, to_out, to_skid, skid_to_out;

    always_comb begin
        redirect   = 1'b1;
        target_raw = 32'h0;
        case (PC_SRC)
            3'b001:  target_raw = JALR;
            3'b010:  target_raw = BRANCH;
            3'b011:  target_raw = JAL;
            3'b100:  target_raw = MTVEC;
            3'b101:  target_raw = MEPC;
            default: redirect   = 1'b0;
        endcase
    end

    // Redirect outranks ACK and STALL: an ACK in a redirect cycle is dropped.
    always_comb begin
        state_nxt   = state;
        accept      = 1'b0;
        to_out      = 1'b0;
        to_skid     = 1'b0;
        skid_to_out = 1'b0;
        case (state)
            S_IDLE: state_nxt = S_REQ;
            S_REQ: begin
                if (redirect) begin
                    state_nxt = IMEM_ACK ? S_REQ : S_DRAIN;
                end else if (IMEM_ACK) begin
                    accept = 1'b1;
                    if (!IF_VALID || !STALL) begin
                        to_out = 1'b1;
                    end else begin
                        to_skid   = 1'b1;
                        state_nxt = S_HOLD;
                    end
                end
            end
            S_DRAIN: begin
                if (IMEM_ACK) state_nxt = S_REQ;
            end
            S_HOLD: begin
                if (redirect) begin
                    state_nxt = S_REQ;
                end else if (!STALL) begin
                    skid_to_out = 1'b1;
                    state_nxt   = S_REQ;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign IMEM_REQ  = (state == S_REQ) && !skid_valid;
    assign IMEM_ADDR = fpc;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= S_IDLE;
            fpc        <= RESET_VEC;
            IF_VALID   <= 1'b0;
            IF_PC      <= 32'h0;
            IF_IR      <= 32'h0000_0013;
            skid_valid <= 1'b0;
            skid_pc    <= 32'h0;
            skid_ir    <= 32'h0;
        end else begin
            state <= state_nxt;
            if (redirect)    fpc <= target_raw & ~32'h3;
            else if (accept) fpc <= fpc + 32'd4;

            if (redirect) begin
                IF_VALID   <= 1'b0;
                skid_valid <= 1'b0;
            end else if (to_out) begin
                IF_VALID <= 1'b1;
                IF_PC    <= fpc;
                IF_IR    <= IMEM_RDATA;
            end else if (skid_to_out) begin
                IF_VALID   <= 1'b1;
                IF_PC      <= skid_pc;
                IF_IR      <= skid_ir;
                skid_valid <= 1'b0;
            end else if (!STALL) begin
                IF_VALID <= 1'b0;
            end

            if (to_skid) begin
                skid_valid <= 1'b1;
                skid_pc    <= fpc;
                skid_ir    <= IMEM_RDATA;
            end
        end
    end

`ifdef OTTER_FETCH_MISALIGN_EN
    // The flag rides with the first instruction fetched after a bit[1] redirect.
    logic mis_pend, if_mis, skid_mis;

    always_ff @(posedge CLK) begin
        if (RST) begin
            mis_pend <= 1'b0;
            if_mis   <= 1'b0;
            skid_mis <= 1'b0;
        end else if (redirect) begin
            mis_pend <= target_raw[1];
            if_mis   <= 1'b0;
            skid_mis <= 1'b0;
        end else begin
            if (accept) mis_pend <= 1'b0;
            if (to_out)           if_mis <= mis_pend;
            else if (skid_to_out) if_mis <= skid_mis;
            else if (!STALL)      if_mis <= 1'b0;
            if (to_skid) skid_mis <= mis_pend;
        end
    end

    assign MISALIGN = if_mis;
`else
    assign MISALIGN = 1'b0;
`endif

endmodule

// File: tb/tb_otter_fetch_stage.sv
// tb/tb_otter_fetch_stage.sv - randomized bench for otter_fetch_stage against a stream-level fetch model
module tb_otter_fetch_stage;

    logic        CLK = 1'b0;
    logic        RST;
    logic [2:0]  PC_SRC;
    logic [31:0] JALR, BRANCH, JAL, MTVEC, MEPC;
    logic        STALL;
    logic        IMEM_REQ;
    logic [31:0] IMEM_ADDR;
    logic        IMEM_ACK;
    logic [31:0] IMEM_RDATA;
    logic        IF_VALID;
    logic [31:0] IF_PC, IF_IR;
    logic        MISALIGN;

    otter_fetch_stage #(.RESET_VEC(32'h0000_0000)) dut (
        .CLK(CLK), .RST(RST), .PC_SRC(PC_SRC),
        .JALR(JALR), .BRANCH(BRANCH), .JAL(JAL), .MTVEC(MTVEC), .MEPC(MEPC),
        .STALL(STALL), .IMEM_REQ(IMEM_REQ), .IMEM_ADDR(IMEM_ADDR),
        .IMEM_ACK(IMEM_ACK), .IMEM_RDATA(IMEM_RDATA),
        .IF_VALID(IF_VALID), .IF_PC(IF_PC), .IF_IR(IF_IR), .MISALIGN(MISALIGN)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Instruction memory contents as a pure function of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC0DE_0013;
    endfunction

    function automatic logic [31:0] rnd_tgt();
        logic [31:0] r;
        r = $urandom;
        if ($urandom_range(0, 7) == 0) r = 32'hFFFF_FFF0 | (r & 32'hF);
        return r;
    endfunction

    logic [31:0] model_pc, exp_addr, mem_addr, raw, tgt;
    logic [31:0] hold_pc, hold_ir;
    logic        mem_busy, hold_pending, mis_flag, redir, exp_mis;
    int          mem_cnt, consumed, redirects;

    initial begin
        RST = 1'b1; PC_SRC = 3'b000; STALL = 1'b0;
        JALR = 0; BRANCH = 0; JAL = 0; MTVEC = 0; MEPC = 0;
        IMEM_ACK = 1'b0; IMEM_RDATA = 32'hDEAD_BEEF;
        @(posedge CLK);
        @(negedge CLK);
        check_eq("rst_if_valid", {31'b0, IF_VALID}, 32'h0);
        check_eq("rst_imem_req", {31'b0, IMEM_REQ}, 32'h0);
        check_eq("rst_if_pc", IF_PC, 32'h0);
        check_eq("rst_if_ir", IF_IR, 32'h0000_0013);
        check_eq("rst_misalign", {31'b0, MISALIGN}, 32'h0);
        check_eq("rst_imem_addr", IMEM_ADDR, 32'h0);
        RST = 1'b0;

        model_pc = 32'h0; exp_addr = 32'h0; mem_addr = 32'h0;
        mem_busy = 1'b0; mem_cnt = 0; hold_pending = 1'b0; mis_flag = 1'b0;
        hold_pc = 0; hold_ir = 0; consumed = 0; redirects = 0;

        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (hold_pending) begin
                check_eq("stall_hold_valid", {31'b0, IF_VALID}, 32'h1);
                check_eq("stall_hold_pc", IF_PC, hold_pc);
                check_eq("stall_hold_ir", IF_IR, hold_ir);
            end

            // Memory: one outstanding request, ack 1..3 cycles later.
            IMEM_ACK = 1'b0;
            IMEM_RDATA = 32'hDEAD_BEEF;
            if (mem_busy) begin
                if (IMEM_REQ) check_eq("req_addr_stable", IMEM_ADDR, mem_addr);
                mem_cnt--;
                if (mem_cnt == 0) begin
                    IMEM_ACK = 1'b1;
                    IMEM_RDATA = mem_word(mem_addr);
                    mem_busy = 1'b0;
                end
            end else if (IMEM_REQ) begin
                check_eq("req_addr", IMEM_ADDR, exp_addr);
                exp_addr = exp_addr + 32'd4;
                mem_addr = IMEM_ADDR;
                mem_busy = 1'b1;
                mem_cnt = $urandom_range(1, 3);
            end

            STALL = ($urandom_range(0, 2) == 0);
            JALR = rnd_tgt(); BRANCH = rnd_tgt(); JAL = rnd_tgt();
            MTVEC = rnd_tgt(); MEPC = rnd_tgt();
            if ($urandom_range(0, 11) == 0)      PC_SRC = 3'($urandom_range(1, 5));
            else if ($urandom_range(0, 19) == 0) PC_SRC = 3'($urandom_range(6, 7));
            else                                 PC_SRC = 3'b000;

            case (PC_SRC)
                3'b001:  raw = JALR;
                3'b010:  raw = BRANCH;
                3'b011:  raw = JAL;
                3'b100:  raw = MTVEC;
                3'b101:  raw = MEPC;
                default: raw = 32'h0;
            endcase
            redir = (PC_SRC >= 3'b001) && (PC_SRC <= 3'b101);
            tgt = raw & ~32'h3;

            // Decode takes the displayed instruction at this edge.
            if (IF_VALID && !STALL && !redir) begin
                check_eq("if_pc", IF_PC, model_pc);
                check_eq("if_ir", IF_IR, mem_word(model_pc));
`ifdef OTTER_FETCH_MISALIGN_EN
                exp_mis = mis_flag;
`else
                exp_mis = 1'b0;
`endif
                check_eq("misalign", {31'b0, MISALIGN}, {31'b0, exp_mis});
                mis_flag = 1'b0;
                model_pc = model_pc + 32'd4;
                consumed++;
            end
            hold_pending = IF_VALID && STALL && !redir;
            hold_pc = IF_PC;
            hold_ir = IF_IR;
            if (redir) begin
                model_pc = tgt;
                exp_addr = tgt;
                mis_flag = raw[1];
                redirects++;
            end

            @(negedge CLK);
            if (redir) check_eq("redirect_squash", {31'b0, IF_VALID}, 32'h0);
        end

        check_eq("progress", {31'b0, consumed > 300}, 32'h1);
        check_eq("redirect_seen", {31'b0, redirects > 20}, 32'h1);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
